// File: rtl/pybuf_pkg.sv
// Shared types and constants for the multi-channel TX payload buffer.
package pybuf_pkg;

    localparam int WORD_W = 32;
    localparam int RD_LAT = 2;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        READY = 2'd1,
        OPEN  = 2'd2
    } bank_state_e;

endpackage

// File: rtl/pybuf_dpram.sv
// Single-write / single-read synchronous payload RAM with one-cycle read latency.
module pybuf_dpram
    import pybuf_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/pytx_mcbufctrl.sv
// Multi-channel ping-pong TX payload buffer with per-channel bank FSMs and a bit-serial read port.
// Optional build macro PYTXBUF_FLUSH_EN adds the bsm_flush input.
module pytx_mcbufctrl
    import pybuf_pkg::*;
#(
    parameter int NCH = 2,
    parameter int AW  = 8,
    parameter int BCW = 13,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk_6M,
    input  logic              rstz,
    input  logic              bsm_cs,
    input  logic [CHW-1:0]    bsm_ch,
    input  logic [AW-1:0]     bsm_addr,
    input  logic [WORD_W-1:0] bsm_din,
    input  logic              bsm_we,
    input  logic              bsm_commit,
    input  logic [BCW-1:0]    bsm_len,
`ifdef PYTXBUF_FLUSH_EN
    input  logic              bsm_flush,
`endif
    input  logic              lnctrl_start,
    input  logic [CHW-1:0]    lnctrl_ch,
    input  logic              lnctrl_rd,
    input  logic [BCW-1:0]    lnctrl_bitcount,
    input  logic              lnctrl_ack,
    input  logic              lnctrl_nak,
    output logic              lnctrl_bitout,
    output logic              lnctrl_bitvalid,
    output logic              lnctrl_last,
    output logic              lnctrl_empty,
    output logic [NCH-1:0]    ch_ready,
    output logic [NCH-1:0]    ch_full,
    output logic [NCH-1:0]    txseqn,
    output logic              bsm_err
);

    localparam int RAM_AW = CHW + 1 + AW;

    logic flush;
`ifdef PYTXBUF_FLUSH_EN
    assign flush = bsm_flush;
`else
    assign flush = 1'b0;
`endif

    logic [NCH-1:0]          wfree, rd_open, wbank, rbank, err_v, empty_v;
    logic [NCH-1:0][BCW-1:0] rd_len;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        bank_state_e    st   [2];
        bank_state_e    st_n [2];
        logic [BCW-1:0] len  [2];
        logic           wb, rb, seqn, rdy_q, full_q;
        logic           sel_b, sel_l, flush_hit, is_open;
        logic           start_ok, ack_ok, nak_ok, wfree_eff, commit_ok;

        assign sel_b     = (bsm_ch == CHW'(g));
        assign sel_l     = (lnctrl_ch == CHW'(g));
        assign flush_hit = flush & sel_b;
        assign is_open   = (st[rb] == OPEN);
        assign start_ok  = lnctrl_start & sel_l & ~is_open & (st[rb] == READY);
        assign nak_ok    = lnctrl_nak & sel_l & is_open;
        assign ack_ok    = lnctrl_ack & ~lnctrl_nak & sel_l & is_open;
        // When both banks are busy, wbank == rbank, so an ACK in the same cycle frees the commit target.
        assign wfree_eff = (st[wb] == FREE) | (ack_ok & (wb == rb));
        assign commit_ok = bsm_commit & sel_b & wfree_eff & ~flush_hit;

        always_comb begin
            st_n = st;
            if (start_ok) st_n[rb] = OPEN;
            if (nak_ok)   st_n[rb] = READY;
            if (ack_ok)   st_n[rb] = FREE;
            if (commit_ok) st_n[wb] = READY;
            if (flush_hit) begin
                st_n[0] = FREE;
                st_n[1] = FREE;
            end
        end

        always_ff @(posedge clk_6M or negedge rstz) begin
            if (!rstz) begin
                st[0]  <= FREE;
                st[1]  <= FREE;
                len[0] <= '0;
                len[1] <= '0;
                wb     <= 1'b0;
                rb     <= 1'b0;
                seqn   <= 1'b0;
                rdy_q  <= 1'b0;
                full_q <= 1'b0;
            end else begin
                st[0]  <= st_n[0];
                st[1]  <= st_n[1];
                rdy_q  <= (st_n[0] == READY) | (st_n[1] == READY);
                full_q <= (st_n[0] != FREE) & (st_n[1] != FREE);
                if (flush_hit) begin
                    wb <= 1'b0;
                    rb <= 1'b0;
                end else begin
                    if (commit_ok) begin
                        wb      <= ~wb;
                        len[wb] <= bsm_len;
                    end
                    if (ack_ok) begin
                        rb   <= ~rb;
                        seqn <= ~seqn;
                    end
                end
            end
        end

        assign wfree[g]    = (st[wb] == FREE);
        assign rd_open[g]  = is_open;
        assign wbank[g]    = wb;
        assign rbank[g]    = rb;
        assign rd_len[g]   = len[rb];
        assign err_v[g]    = sel_b & ((bsm_cs & bsm_we & (st[wb] != FREE)) | (bsm_commit & ~wfree_eff));
        assign empty_v[g]  = lnctrl_start & sel_l & ~is_open & (st[rb] != READY);
        assign ch_ready[g] = rdy_q;
        assign ch_full[g]  = full_q;
        assign txseqn[g]   = seqn;
    end

    logic              ram_we;
    logic [RAM_AW-1:0] ram_waddr, ram_raddr;
    logic [WORD_W-1:0] ram_rdata;

    assign ram_we    = bsm_cs & bsm_we & wfree[bsm_ch];
    assign ram_waddr = {bsm_ch, wbank[bsm_ch], bsm_addr};
    assign ram_raddr = {lnctrl_ch, rbank[lnctrl_ch], lnctrl_bitcount[BCW-1:5]};

    pybuf_dpram #(.ADDR_W(RAM_AW)) u_ram (
        .clk   (clk_6M),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (bsm_din),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Stage 1 tracks the request alongside the RAM read; stage 2 selects the bit.
    logic           s1_valid, s1_last;
    logic [4:0]     s1_sel;
    logic [CHW-1:0] s1_ch;
    logic           rd_hit, kill_new, kill_old;

    assign rd_hit   = lnctrl_rd & rd_open[lnctrl_ch] & (lnctrl_bitcount < rd_len[lnctrl_ch]);
    assign kill_new = flush & (bsm_ch == lnctrl_ch);
    assign kill_old = flush & (bsm_ch == s1_ch);

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            s1_valid        <= 1'b0;
            s1_last         <= 1'b0;
            s1_sel          <= '0;
            s1_ch           <= '0;
            lnctrl_bitout   <= 1'b0;
            lnctrl_bitvalid <= 1'b0;
            lnctrl_last     <= 1'b0;
            lnctrl_empty    <= 1'b0;
            bsm_err         <= 1'b0;
        end else begin
            s1_valid        <= rd_hit & ~kill_new;
            s1_last         <= (lnctrl_bitcount == rd_len[lnctrl_ch] - BCW'(1));
            s1_sel          <= lnctrl_bitcount[4:0];
            s1_ch           <= lnctrl_ch;
            lnctrl_bitout   <= s1_valid & ram_rdata[s1_sel];
            lnctrl_bitvalid <= s1_valid & ~kill_old;
            lnctrl_last     <= s1_valid & ~kill_old & s1_last;
            lnctrl_empty    <= |empty_v;
            bsm_err         <= |err_v;
        end
    end

endmodule
